// File: rtl/sum_threshold_detect_if.sv
// sum_threshold_detect_if: valid/ready sample stream carrying a signed sum, end-of-packet and a detect flag
interface sum_threshold_detect_if #(
  parameter int WIDTH = 26
) ();
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tuser;
  logic             tvalid;
  logic             tready;
  modport master (output tdata, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/sum_threshold_detect.sv
// sum_threshold_detect: one-stage pass-through of a signed sum stream that flags the
// sample completing a run above threshold_hi, re-arming after a drop below threshold_lo plus holdoff
module sum_threshold_detect #(
  parameter int WIDTH      = 26,
  parameter int RUN_WIDTH  = 8,
  parameter int HOLD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      threshold_hi,
  input  logic [WIDTH-1:0]      threshold_lo,
  input  logic [RUN_WIDTH-1:0]  min_run,
  input  logic [HOLD_WIDTH-1:0] holdoff,
  sum_threshold_detect_if.slave  up,
  sum_threshold_detect_if.master down,
  output logic                  active
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
  state_t                state;
  logic [RUN_WIDTH-1:0]  run_cnt;
  logic [RUN_WIDTH-1:0]  run_min;
  logic [RUN_WIDTH:0]    run_nxt;
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic                  beat, hi, lo, trig, long_hold;
  assign up.tready = ~clear & (down.tready | ~down.tvalid);
  assign beat      = up.tvalid & up.tready;
  assign hi        = $signed(up.tdata) > $signed(threshold_hi);
  assign lo        = $signed(up.tdata) < $signed(threshold_lo);
  assign run_min   = (min_run == '0) ? RUN_WIDTH'(1) : min_run;
  assign run_nxt   = {1'b0, run_cnt} + (RUN_WIDTH+1)'(1);
  assign trig      = (state == IDLE) && hi && (run_nxt >= {1'b0, run_min});
  assign long_hold = holdoff > HOLD_WIDTH'(1);
  assign active    = state == ACTIVE;
  // The release beat itself counts as the first holdoff beat, so holdoff of 0 or 1 re-arms at once.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      down.tvalid <= 1'b0;
      down.tdata  <= '0;
      down.tlast  <= 1'b0;
      down.tuser  <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      run_cnt     <= '0;
      hold_cnt    <= '0;
      down.tvalid <= 1'b0;
    end else begin
      if (up.tready) down.tvalid <= up.tvalid;
      if (beat) begin
        down.tdata <= up.tdata;
        down.tlast <= up.tlast;
        down.tuser <= trig;
        case (state)
          IDLE: begin
            run_cnt <= (trig || !hi) ? '0 : (&run_cnt ? run_cnt : run_nxt[RUN_WIDTH-1:0]);
            if (trig) state <= ACTIVE;
          end
          ACTIVE: if (lo) begin
            state    <= long_hold ? HOLD : IDLE;
            hold_cnt <= long_hold ? holdoff - HOLD_WIDTH'(1) : '0;
          end
          default: begin
            hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
            run_cnt  <= '0;
            if (hold_cnt == HOLD_WIDTH'(1)) state <= IDLE;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_sum_threshold_detect.sv
// tb_sum_threshold_detect: directed vectors for the threshold detector with hand-computed flags
module tb_sum_threshold_detect;
  localparam int W = 26;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         active;
  logic [W-1:0] threshold_hi, threshold_lo;
  logic [7:0]   min_run;
  logic [15:0]  holdoff;
  int           n_cmp = 0, n_bad = 0;
  int           idx, got, ntrig, trig_at;
  logic         rdy, stall, acc;
  logic [W-1:0] held;
  logic [W-1:0] basic [9] = '{0, 101, 101, 101, 101, 40, 101, 101, 101};
  logic [8:0]   basic_user = 9'b1_0000_1000;
  logic [8:0]   basic_act  = 9'b1_0001_1000;
  logic [W-1:0] broken [6] = '{101, 101, 100, 101, 101, 101};
  logic [W-1:0] hold_v [7] = '{200, 10, 200, 200, 200, 200, 200};
  logic [6:0]   hold_user  = 7'b010_0001;
  logic [6:0]   hold_act   = 7'b110_0001;

  sum_threshold_detect_if #(.WIDTH(W)) up_if ();
  sum_threshold_detect_if #(.WIDTH(W)) down_if ();

  sum_threshold_detect #(.WIDTH(W), .RUN_WIDTH(8), .HOLD_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .threshold_hi(threshold_hi), .threshold_lo(threshold_lo),
    .min_run(min_run), .holdoff(holdoff),
    .up(up_if), .down(down_if), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input logic eu, input logic ea);
    up_if.tdata = d;
    up_if.tlast = l;
    up_if.tvalid = 1'b1;
    down_if.tready = 1'b1;
    @(posedge clk); #1;
    up_if.tvalid = 1'b0;
    chk("out_valid", down_if.tvalid, 1);
    chk("out_data", down_if.tdata, d);
    chk("out_last", down_if.tlast, l);
    chk("out_user", down_if.tuser, eu);
    chk("active", active, ea);
  endtask

  task automatic pulse_clear(input logic with_beat);
    up_if.tvalid = with_beat;
    up_if.tdata = 200;
    clear = 1'b1;
    #1;
    chk("clear_ready", up_if.tready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    up_if.tvalid = 1'b0;
    chk("clear_valid", down_if.tvalid, 0);
    chk("clear_active", active, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    up_if.tvalid = 1'b0; up_if.tdata = '0; up_if.tlast = 1'b0; up_if.tuser = 1'b0;
    down_if.tready = 1'b1;
    threshold_hi = 100; threshold_lo = 50; min_run = 3; holdoff = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", down_if.tvalid, 0);
    chk("rst_data", down_if.tdata, 0);
    chk("rst_user", down_if.tuser, 0);
    chk("rst_active", active, 0);
    chk("rst_ready", up_if.tready, 1);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) send(basic[k], k == 8, basic_user[k], basic_act[k]);
    pulse_clear(1'b0);
    for (int k = 0; k < 6; k++) send(broken[k], 1'b0, k == 5, k == 5);
    pulse_clear(1'b0);
    min_run = 1; holdoff = 4;
    for (int k = 0; k < 7; k++) send(hold_v[k], 1'b0, hold_user[k], hold_act[k]);
    min_run = 2;
    send(10, 1'b0, 1'b0, 1'b0);
    send(200, 1'b0, 1'b0, 1'b0);
    pulse_clear(1'b1);
    send(200, 1'b0, 1'b0, 1'b0);
    send(200, 1'b0, 1'b1, 1'b1);
    pulse_clear(1'b0);
    min_run = 3; holdoff = 0;
    idx = 0; got = 0;
    for (int c = 0; c < 400 && got < 9; c++) begin
      up_if.tvalid = idx < 9;
      up_if.tdata = basic[idx < 9 ? idx : 8];
      up_if.tlast = idx == 8;
      rdy = 1'($urandom_range(0, 1));
      down_if.tready = rdy;
      #2;
      stall = down_if.tvalid && !rdy;
      held = down_if.tdata;
      if (down_if.tvalid && rdy) begin
        chk("bp_data", down_if.tdata, basic[got]);
        chk("bp_user", down_if.tuser, basic_user[got]);
        got++;
      end
      acc = up_if.tvalid && up_if.tready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (stall) begin
        chk("bp_hold_valid", down_if.tvalid, 1);
        chk("bp_hold_data", down_if.tdata, held);
      end
    end
    up_if.tvalid = 1'b0;
    down_if.tready = 1'b1;
    chk("bp_count", got, 9);
    chk("bp_active", active, 1);
    send(101, 1'b1, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", down_if.tvalid, 0);
    chk("arst_data", down_if.tdata, 0);
    chk("arst_last", down_if.tlast, 0);
    chk("arst_user", down_if.tuser, 0);
    chk("arst_active", active, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    threshold_hi = W'(-5); threshold_lo = W'(-100); min_run = 0;
    send(26'h2000000, 1'b0, 1'b0, 1'b0);
    send(W'(-4), 1'b0, 1'b1, 1'b1);
    pulse_clear(1'b0);
    threshold_hi = 100; threshold_lo = 50; min_run = 255;
    ntrig = 0; trig_at = 0;
    up_if.tdata = 101; up_if.tlast = 1'b0; up_if.tvalid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (down_if.tvalid && down_if.tuser) begin
        ntrig++;
        trig_at = k + 1;
      end
    end
    up_if.tvalid = 1'b0;
    chk("long_run_count", ntrig, 1);
    chk("long_run_at", trig_at, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
